// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss handler: FSM state encoding and default widths.
package cache_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CHECK,
        ST_MEM_RD,
        ST_FILL,
        ST_WRITE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/cache_miss_handler_sat_counter.sv
// Saturating up-counter with a synchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_miss_handler.sv
// Control stage in front of a direct-mapped write-through cache: load lookup, miss fetch
// and fill over a req/ack memory handshake, and write-through stores.
module cache_miss_handler
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wr_data,
    output logic                  cache_mem_read,
    output logic                  cache_mem_write,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic                  ready_q, ready_d;
    logic                  hit_en, miss_en;

    // Outputs are registered, so each is computed for the state being entered.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_data_d = wr_data_q;
        rdata_d   = '0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        req_d     = 1'b0;
        we_d      = 1'b0;
        ready_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    if (cpu_we) begin
                        state_d   = ST_WRITE;
                        wr_data_d = cpu_wdata;
                        wr_d      = 1'b1;
                        req_d     = 1'b1;
                        we_d      = 1'b1;
                    end else begin
                        state_d = ST_LOOKUP;
                        rd_d    = 1'b1;
                    end
                end
            end
            ST_LOOKUP: state_d = ST_CHECK;
            ST_CHECK: begin
                if (cache_hit) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    rdata_d = cache_rdata;
                end else begin
                    state_d = ST_MEM_RD;
                    req_d   = 1'b1;
                end
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    state_d   = ST_FILL;
                    wr_data_d = mem_rdata;
                    wr_d      = 1'b1;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_FILL: begin
                state_d = ST_RESP;
                ready_d = 1'b1;
                rdata_d = wr_data_q;
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                end else begin
                    req_d = 1'b1;
                    we_d  = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_data_q <= '0;
            rdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_data_q <= wr_data_d;
            rdata_q   <= rdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            req_q     <= req_d;
            we_q      <= we_d;
            ready_q   <= ready_d;
        end
    end

    assign hit_en  = (state_q == ST_CHECK) && cache_hit;
    assign miss_en = (state_q == ST_CHECK) && !cache_hit;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .clr_n (rst),
        .en    (hit_en),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .clr_n (rst),
        .en    (miss_en),
        .count (miss_count)
    );

    assign cpu_ready       = ready_q;
    assign cpu_rdata       = rdata_q;
    assign cache_addr      = addr_q;
    assign cache_wr_data   = wr_data_q;
    assign cache_mem_read  = rd_q;
    assign cache_mem_write = wr_q;
    assign mem_req         = req_q;
    assign mem_we          = we_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Bench for cache_miss_handler: behavioural cache and memory around the DUT, directed and
// random load/store traffic checked against a transaction-level reference model.
module tb_cache_miss_handler;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wr_data;
    logic          cache_mem_read;
    logic          cache_mem_write;
    logic          cache_hit = 1'b0;
    logic [DW-1:0] cache_rdata = '0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    always #5 clk = ~clk;

    cache_miss_handler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_ready       (cpu_ready),
        .cpu_rdata       (cpu_rdata),
        .cache_addr      (cache_addr),
        .cache_wr_data   (cache_wr_data),
        .cache_mem_read  (cache_mem_read),
        .cache_mem_write (cache_mem_write),
        .cache_hit       (cache_hit),
        .cache_rdata     (cache_rdata),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    function automatic logic [31:0] init_word(input logic [7:0] a);
        if (a == 8'h08) return 32'h12345678;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // Direct-mapped cache: 16 lines, index = addr[3:0], tag = addr[7:4].
    logic [15:0] c_valid = '0;
    logic [3:0]  c_tag  [16];
    logic [31:0] c_data [16];
    int          fill_cnt = 0;
    logic [31:0] last_fill = '0;

    always @(posedge clk) begin
        cache_hit <= 1'b0;
        if (cache_mem_read) begin
            cache_hit   <= c_valid[cache_addr[3:0]] && (c_tag[cache_addr[3:0]] == cache_addr[7:4]);
            cache_rdata <= c_data[cache_addr[3:0]];
        end
        if (cache_mem_write) begin
            c_valid[cache_addr[3:0]] <= 1'b1;
            c_tag[cache_addr[3:0]]   <= cache_addr[7:4];
            c_data[cache_addr[3:0]]  <= cache_wr_data;
            fill_cnt  <= fill_cnt + 1;
            last_fill <= cache_wr_data;
        end
    end

    // Backing memory: acks ack_delay cycles after mem_req is first seen.
    logic [31:0]  mem_arr [256];
    logic [255:0] mem_wr = '0;
    int           ack_delay = 0;
    logic         ack_hold = 1'b0;
    int           req_cycles = 0;
    int           req_cyc_total = 0;
    logic [7:0]   ack_addr = '0;
    logic         ack_we = 1'b0;
    logic [31:0]  ack_wdata = '0;

    always @(negedge clk) begin
        if (mem_req) begin
            req_cyc_total++;
            if (req_cycles == ack_delay) begin
                mem_ack   = 1'b1;
                ack_addr  = mem_addr;
                ack_we    = mem_we;
                ack_wdata = mem_wdata;
                if (mem_we) begin
                    mem_arr[mem_addr] = mem_wdata;
                    mem_wr[mem_addr]  = 1'b1;
                    mem_rdata = '0;
                end else begin
                    mem_rdata = mem_wr[mem_addr] ? mem_arr[mem_addr] : init_word(mem_addr);
                end
            end else begin
                mem_ack = 1'b0;
            end
            req_cycles++;
        end else begin
            mem_ack    = ack_hold;
            mem_rdata  = 32'hA5A5_0F0F;
            req_cycles = 0;
        end
    end

    // Reference model state, owned by the stimulus process.
    int           checks = 0;
    int           passes = 0;
    logic [31:0]  ref_mem [256];
    logic [255:0] ref_wr = '0;
    logic [15:0]  ref_valid = '0;
    logic [3:0]   ref_tag [16];
    int           ref_hits = 0;
    int           ref_misses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check(tag, {28'h0, cpu_ready, cache_mem_read, cache_mem_write, mem_req}, 32'h0);
    endtask

    task automatic run_txn(input logic we, input logic [7:0] a, input logic [31:0] d, input int k);
        logic [3:0]  idx;
        logic        exp_hit;
        logic [31:0] exp_data;
        int          exp_lat;
        int          fills0;
        int          reqs0;
        int          n;
        logic        got;
        logic [31:0] rdata;
        idx      = a[3:0];
        exp_hit  = !we && ref_valid[idx] && (ref_tag[idx] == a[7:4]);
        exp_data = we ? 32'h0 : (ref_wr[a] ? ref_mem[a] : init_word(a));
        exp_lat  = we ? 2 + k : (exp_hit ? 3 : 5 + k);
        ack_delay = k;
        fills0 = fill_cnt;
        reqs0  = req_cyc_total;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        n = 0; got = 1'b0; rdata = '0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (cpu_ready) begin
                got   = 1'b1;
                rdata = cpu_rdata;
            end
        end
        check("ready_seen", {31'h0, got}, 32'h1);
        if (!we) begin
            if (exp_hit) ref_hits = (ref_hits < 65535) ? ref_hits + 1 : ref_hits;
            else ref_misses = (ref_misses < 65535) ? ref_misses + 1 : ref_misses;
        end
        check("latency", n, exp_lat);
        check("rdata", rdata, exp_data);
        check("hit_count", 32'(hit_count), ref_hits);
        check("miss_count", 32'(miss_count), ref_misses);
        check("cache_writes", fill_cnt - fills0, exp_hit ? 0 : 1);
        check("mem_req_cycles", req_cyc_total - reqs0, exp_hit ? 0 : k + 1);
        if (!exp_hit) begin
            check("mem_addr", {24'h0, ack_addr}, {24'h0, a});
            check("mem_we", {31'h0, ack_we}, {31'h0, we});
            check("fill_data", last_fill, we ? d : exp_data);
            if (we) check("mem_wdata", ack_wdata, d);
        end
        $display("txn %s addr=0x%02h data=0x%08h k=%0d lat=%0d hit=%0d", we ? "ST" : "LD",
                 a, we ? d : rdata, k, n, exp_hit);
        // Request deliberately held through the RESP edge; it must not be re-accepted.
        @(negedge clk);
        cpu_req = 1'b0;
        check_idle("after_resp");
        @(negedge clk);
        check_idle("after_resp2");
        if (we) begin
            ref_mem[a] = d;
            ref_wr[a]  = 1'b1;
        end
        if (!exp_hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[7:4];
        end
    endtask

    initial begin
        logic        r_we;
        logic [7:0]  r_a;
        logic [31:0] r_d;
        int          r_k;
        int          fills_before;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset_strobes");
        check("reset_rdata", cpu_rdata, 32'h0);
        check("reset_addr", {16'h0, cache_addr, mem_addr}, 32'h0);
        check("reset_counts", {hit_count, miss_count}, 32'h0);
        check("reset_we", {31'h0, mem_we}, 32'h0);
        rst = 1'b1;

        run_txn(1'b0, 8'h08, 32'h0, 2);
        run_txn(1'b0, 8'h08, 32'h0, 0);
        run_txn(1'b1, 8'h08, 32'hDEADBEEF, 0);
        run_txn(1'b0, 8'h08, 32'h0, 0);
        run_txn(1'b0, 8'h18, 32'h0, 1);
        run_txn(1'b0, 8'h08, 32'h0, 3);

        // Acknowledge held high while idle must not move the FSM.
        ack_hold = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_idle("ack_while_idle");
        end
        ack_hold = 1'b0;
        @(negedge clk);

        // Reset while waiting for memory on a load miss.
        fills_before = fill_cnt;
        ack_delay = 1000;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h37;
        repeat (4) @(negedge clk);
        check("mem_rd_pending", {31'h0, mem_req}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        check_idle("reset_mid_strobes");
        check("reset_mid_counts", {hit_count, miss_count}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        ref_hits = 0;
        ref_misses = 0;
        ack_hold = 1'b1;
        @(negedge clk);
        ack_hold = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("stale_ack");
        end
        check("no_fill_after_reset", fill_cnt - fills_before, 0);

        for (int i = 0; i < 40; i++) begin
            r_we = ($urandom_range(0, 3) == 0);
            r_a  = 8'($urandom_range(0, 47));
            r_d  = $urandom;
            r_k  = $urandom_range(0, 3);
            run_txn(r_we, r_a, r_d, r_k);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Control stage in front of the direct-mapped cache. It accepts one CPU load/store at a time and drives the cache's `addr`/`wr_data`/`mem_read`/`mem_write` ports. Loads are looked up in the cache; on a miss the handler fetches the word from backing memory over a req/ack handshake, fills the cache and returns the data. Stores are written through to both the cache and memory.

## Interface
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 8, word address width
- `CNT_WIDTH`, 16, width of the hit and miss counters

- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `cpu_req`  in  1  request; held high until `cpu_ready`
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  ADDR_WIDTH  request address
- `cpu_wdata`  in  DATA_WIDTH  store data
- `cpu_ready`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  DATA_WIDTH  load data; valid while `cpu_ready` = 1
- `cache_addr`  out  ADDR_WIDTH  to the cache `addr` port
- `cache_wr_data`  out  DATA_WIDTH  to the cache `wr_data` port
- `cache_mem_read`  out  1  cache lookup strobe
- `cache_mem_write`  out  1  cache write strobe
- `cache_hit`  in  1  cache `hit`, valid the cycle after `cache_mem_read`
- `cache_rdata`  in  DATA_WIDTH  cache `read_data`, valid with `cache_hit`
- `mem_req`  out  1  memory request; held until `mem_ack`
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_ack`  in  1  memory done; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  DATA_WIDTH  memory read data
- `hit_count`, `miss_count`  out  CNT_WIDTH  saturating load-hit and load-miss counters

## Operation
- While `rst` = 0 at an edge, every output and register is cleared to 0 and the FSM goes to IDLE.
- IDLE
  - `cpu_req` is sampled only in IDLE.
  - On `cpu_req` = 1, `cpu_addr`, `cpu_we` and `cpu_wdata` are latched.
  - A load goes to LOOKUP; a store goes to WRITE.
- LOOKUP: `cache_mem_read` = 1 and `cache_addr` = latched address for one cycle, then go to CHECK.
- CHECK: sample `cache_hit`.
  - Hit: latch `cache_rdata`, increment `hit_count`, go to RESP.
  - Miss: increment `miss_count`, go to MEM_RD.
- MEM_RD
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = latched address, all held stable.
  - On `mem_ack`, latch `mem_rdata` and go to FILL.
- FILL: `cache_mem_write` = 1 and `cache_wr_data` = fetched word for one cycle, then go to RESP.
- WRITE
  - On entry, `cache_mem_write` = 1 for one cycle only.
  - `mem_req` = 1, `mem_we` = 1, `mem_wdata` = latched data, held until `mem_ack`, then go to RESP.
- RESP: `cpu_ready` = 1 for one cycle with `cpu_rdata` valid (0 for a store), then go to IDLE.
- Cache strobes and `mem_req` are never asserted in IDLE or RESP.
- `mem_ack` is ignored whenever `mem_req` = 0.
- Counters saturate at all-ones and do not wrap. Stores do not count.

## Timing
- Cycle 0 is the IDLE edge where `cpu_req` is accepted.
- Load hit: `cpu_ready` in cycle 3.
- Load miss: `mem_req` rises in cycle 3. If `mem_ack` arrives in cycle 3+k (k ≥ 0), FILL is in cycle 4+k and `cpu_ready` in cycle 5+k.
- Store: `cache_mem_write` and `mem_req` rise in cycle 1. If `mem_ack` arrives in cycle 1+k, `cpu_ready` is in cycle 2+k.
- A request still high during RESP is not re-accepted. A new request is accepted at the earliest in the cycle after RESP.
- Reset mid-operation (any state): `mem_req` and all strobes drop at the next edge, no `cpu_ready` is issued, and counters clear. Memory must tolerate an abandoned request.
- Bank-conflict eviction needs no special handling: a write-through cache holds no dirty data.

## Structure
- Shared package `cache_pkg`: FSM state encoding (IDLE, LOOKUP, CHECK, MEM_RD, FILL, WRITE, RESP) and the default width constants.
- One sub-module, `sat_counter`, with parameter width, `en` input and a synchronous active-low clear. It is instantiated twice, for the hit and miss counters.

## Test plan
- Reset, then load 0x08; memory model acks 2 cycles after `mem_req` with 0x12345678 -> `mem_addr` = 0x08, one `cache_mem_write` with 0x12345678, `cpu_rdata` = 0x12345678, `miss_count` = 1.
- Reload 0x08 -> no `mem_req`, `cpu_ready` 3 cycles after accept, data 0x12345678, `hit_count` = 1.
- Store 0xDEADBEEF to 0x08 with immediate ack -> `mem_we` = 1, `mem_wdata` = 0xDEADBEEF, `cpu_ready` at cycle 2. A following load of 0x08 hits with 0xDEADBEEF.
- Load 0x18 (same index, different tag) -> miss and fill. A following load of 0x08 misses again; `miss_count` increments each time.
- Drive `rst` low while in MEM_RD before ack -> `mem_req` = 0 next edge, no `cpu_ready`, counters = 0. A later ack pulse is ignored.
- Hold `mem_ack` = 1 while idle, and hold `cpu_req` high through RESP -> no spurious transitions, exactly one `cpu_ready` per accepted request.
